fp_result_checker: RTL and testbench
====================================

# fp_result_checker

Parametrised cycle-bounded result checker for the pipelined processor's floating-point register file. On a start pulse it watches NCH observed register values (e.g. f4, f3, f2 of the FP register file) every clock. It declares pass once every enabled channel has matched its expected value for HOLD consecutive cycles, and declares fail if that has not happened after MAX_CYCLES cycles. It sits beside the Top instance in instruction-level benches and in on-chip debug builds, and replaces fixed-count display-and-stop checking with a synthesizable pass/fail verdict.

## Interface
- WIDTH, 32: bits per observed register.
- NCH, 3: number of watched channels.
- CNT_W, 8: width of cycle counters; MAX_CYCLES < 2^CNT_W.
- MAX_CYCLES, 6: run-cycle budget before fail.
- HOLD, 1: consecutive all-match cycles required for pass (1 ≤ HOLD ≤ MAX_CYCLES).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a check run; honoured in IDLE or DONE, ignored in RUN.
- obs  in  NCH*WIDTH  observed registers; channel i at [i*WIDTH +: WIDTH].
- exp  in  NCH*WIDTH  expected values, same packing; sampled every RUN cycle.
- en  in  NCH  channel enable; disabled channels always count as matching.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  verdict: matched; valid while done.
- fail  out  1  verdict: budget exhausted; valid while done.
- cycle_cnt  out  CNT_W  current run cycle (1-based).
- match_cycle  out  CNT_W  cycle at which pass was decided; 0 if none.
- miss_mask  out  NCH  enabled channels mismatching at the deciding cycle.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE; all outputs 0; streak counter 0.
- IDLE/DONE + start: go to RUN. cycle_cnt=1, streak=0, pass=fail=0, match_cycle=0, miss_mask=0.
- Per-channel match: match[i] = ~en[i] | (obs_i == exp_i). This is a bitwise compare; no FP tolerance (+0/−0 differ, NaN payloads compared exactly).
- RUN, each edge: if &match, then streak_next = streak+1, else 0.
  - If streak_next == HOLD: go to DONE, pass=1, match_cycle=cycle_cnt, miss_mask=0.
  - Else if cycle_cnt == MAX_CYCLES: go to DONE, fail=1, miss_mask = en & ~match.
  - Else cycle_cnt++.
- Pass takes priority over fail on the final cycle.
- DONE: all outputs hold until start or reset. start in RUN has no effect.
- en=0 (all disabled): pass at cycle HOLD.
- Reset asserted mid-RUN: immediate return to IDLE, verdict discarded.

## Timing
- obs/exp/en are sampled at each rising edge while in RUN. The first sample is the edge after the one that accepted start.
- Decision latency: registered outputs change at the deciding edge. The earliest pass is the HOLD-th RUN edge; the latest verdict is the MAX_CYCLES-th RUN edge.
- busy/done are mutually exclusive, and pass/fail are mutually exclusive. The one-cycle start→RUN transition shows busy=1 with cycle_cnt=1.
- start held high through DONE restarts on the first DONE cycle. A back-to-back restart costs no idle cycle.
- cycle_cnt never exceeds MAX_CYCLES and never wraps.

## Structure
- Shared package fp_check_pkg: state enum (IDLE/RUN/DONE), default WIDTH/NCH constants, and the channel slicing function.
- Sub-module fp_chan_cmp (WIDTH): one per channel via generate, outputs match[i]. The FSM and counters live in the top module.

## Test plan
- add.s pass: start. The program drives obs = {f4,f3,f2} with f3=0x3F800000, f2=0x40000000, and f4 goes 0→0x40400000 at run cycle 4. exp matches. en=3'b111, HOLD=1, MAX_CYCLES=6. Required: done with pass=1, match_cycle=4, miss_mask=0.
- Timeout: f4 stays 0x00000000 against exp 0x40400000. Required: fail=1 at cycle_cnt=6, miss_mask=3'b100, match_cycle=0.
- HOLD=2 glitch: match at cycle 2, mismatch at cycle 3, match at cycles 4–5. Required: pass at match_cycle=5.
- Channel disable: f4 wrong, en=3'b011. Required: pass at cycle 1. Also en=0 with HOLD=2 → pass at cycle 2.
- Final-cycle tie: first match at cycle 6 (=MAX_CYCLES). Required: pass=1, fail=0. Also: start pulsed in RUN is ignored; start held in DONE restarts with verdict cleared.
- Async reset at RUN cycle 3: outputs 0 immediately without a clock edge, state IDLE. A following start gives cycle_cnt=1.

Source files
------------

// File: rtl/fp_check_pkg.sv
// Shared types and helpers for the FP register-file result checker.
// Holds the run-state encoding, default geometry and channel slicing.
package fp_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_NCH   = 3;

   // Channel i of a packed register bus starts at bit i*width.
   function automatic int chan_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/fp_chan_cmp.sv
// Bitwise compare of one observed FP register against its expected value.
// A disabled channel always reports a match.
module fp_chan_cmp
   import fp_check_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i_obs,
   input  logic [WIDTH-1:0] i_exp,
   input  logic             i_en,
   output logic             o_match
);

   // Exact bit equality: +0/-0 differ and NaN payloads must agree.
   assign o_match = ~i_en | (i_obs == i_exp);

endmodule

// File: rtl/fp_result_checker.sv
// Cycle-bounded pass/fail checker for watched FP register-file channels.
// Passes after HOLD consecutive all-match cycles, fails after MAX_CYCLES.
module fp_result_checker
   import fp_check_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int NCH        = DEF_NCH,
   parameter int CNT_W      = 8,
   parameter int MAX_CYCLES = 6,
   parameter int HOLD       = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic [NCH*WIDTH-1:0] i_obs,
   input  logic [NCH*WIDTH-1:0] i_exp,
   input  logic [NCH-1:0]       i_en,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic                 o_fail,
   output logic [CNT_W-1:0]     o_cycle_cnt,
   output logic [CNT_W-1:0]     o_match_cycle,
   output logic [NCH-1:0]       o_miss_mask,
   output state_t               o_state
);

   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_streak;
   logic [CNT_W-1:0] r_match_cycle;
   logic [NCH-1:0]   r_miss_mask;
   logic             r_pass;
   logic             r_fail;

   logic [NCH-1:0]   w_match;
   logic             w_all_match;
   logic [CNT_W-1:0] w_streak_next;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      fp_chan_cmp #(.WIDTH(WIDTH)) u_cmp (
         .i_obs   (i_obs[chan_lsb(i, WIDTH) +: WIDTH]),
         .i_exp   (i_exp[chan_lsb(i, WIDTH) +: WIDTH]),
         .i_en    (i_en[i]),
         .o_match (w_match[i])
      );
   end

   assign w_all_match = &w_match;

   always_comb begin
      w_streak_next = '0;
      if (w_all_match) w_streak_next = r_streak + ONE_C;
   end

   // Handshake: i_start is a request taken in IDLE or DONE; o_done with
   // o_pass/o_fail is the held response until the next accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_cycle_cnt   <= '0;
         r_streak      <= '0;
         r_match_cycle <= '0;
         r_miss_mask   <= '0;
         r_pass        <= 1'b0;
         r_fail        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  r_state       <= ST_RUN;
                  r_cycle_cnt   <= ONE_C;
                  r_streak      <= '0;
                  r_match_cycle <= '0;
                  r_miss_mask   <= '0;
                  r_pass        <= 1'b0;
                  r_fail        <= 1'b0;
               end
            end
            ST_RUN: begin
               r_streak <= w_streak_next;
               // Pass is tested first so a match on the last budgeted cycle wins.
               if (w_streak_next == HOLD_C) begin
                  r_state       <= ST_DONE;
                  r_pass        <= 1'b1;
                  r_match_cycle <= r_cycle_cnt;
                  r_miss_mask   <= '0;
               end else if (r_cycle_cnt == MAX_C) begin
                  r_state     <= ST_DONE;
                  r_fail      <= 1'b1;
                  r_miss_mask <= i_en & ~w_match;
               end else begin
                  r_cycle_cnt <= r_cycle_cnt + ONE_C;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy        = (r_state == ST_RUN);
   assign o_done        = (r_state == ST_DONE);
   assign o_pass        = r_pass;
   assign o_fail        = r_fail;
   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_match_cycle = r_match_cycle;
   assign o_miss_mask   = r_miss_mask;
   assign o_state       = r_state;

endmodule

// File: tb/tb_fp_result_checker.sv
// Bench for fp_result_checker: two instances (HOLD=1 and HOLD=2) share one
// stimulus stream; expected verdicts are queued and popped when done rises.
module tb_fp_result_checker;
   import fp_check_pkg::*;

   localparam int W   = 32;
   localparam int N   = 3;
   localparam int MAXC = 6;
   localparam logic [W-1:0] F4 = 32'h4040_0000;
   localparam logic [W-1:0] F3 = 32'h3F80_0000;
   localparam logic [W-1:0] F2 = 32'h4000_0000;

   logic clk;
   logic rst_n;
   logic i_start;
   logic [N*W-1:0] i_obs;
   logic [N*W-1:0] i_exp;
   logic [N-1:0]   i_en;

   logic h1_busy, h1_done, h1_pass, h1_fail;
   logic [7:0] h1_cnt, h1_mc;
   logic [N-1:0] h1_miss;
   state_t h1_state;
   logic h2_busy, h2_done, h2_pass, h2_fail;
   logic [7:0] h2_cnt, h2_mc;
   logic [N-1:0] h2_miss;
   state_t h2_state;

   fp_result_checker #(.WIDTH(W), .NCH(N), .CNT_W(8), .MAX_CYCLES(MAXC), .HOLD(1)) u_h1 (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_obs(i_obs), .i_exp(i_exp), .i_en(i_en),
      .o_busy(h1_busy), .o_done(h1_done), .o_pass(h1_pass), .o_fail(h1_fail),
      .o_cycle_cnt(h1_cnt), .o_match_cycle(h1_mc), .o_miss_mask(h1_miss), .o_state(h1_state)
   );

   fp_result_checker #(.WIDTH(W), .NCH(N), .CNT_W(8), .MAX_CYCLES(MAXC), .HOLD(2)) u_h2 (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_obs(i_obs), .i_exp(i_exp), .i_en(i_en),
      .o_busy(h2_busy), .o_done(h2_done), .o_pass(h2_pass), .o_fail(h2_fail),
      .o_cycle_cnt(h2_cnt), .o_match_cycle(h2_mc), .o_miss_mask(h2_miss), .o_state(h2_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [20:0] exp_q1[$];
   logic [20:0] exp_q2[$];
   logic [N*W-1:0] seq_obs[6];
   logic [N*W-1:0] seq_exp[6];
   logic [N-1:0]   seq_en;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [20:0] pk(input bit p, input bit f, input int cnt, input int mc,
                                      input logic [N-1:0] miss);
      return {p, f, 8'(cnt), 8'(mc), miss};
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [N-1:0] miss_at(input int c);
      logic [N-1:0] m;
      m = '0;
      for (int ch = 0; ch < N; ch++)
         if (seq_en[ch] && seq_obs[c][ch*W +: W] != seq_exp[c][ch*W +: W]) m[ch] = 1'b1;
      return m;
   endfunction

   // Verdict = earliest cycle closing a window of `hold` all-matching cycles.
   function automatic logic [20:0] model(input int hold);
      bit ok;
      for (int c = 1; c <= MAXC; c++) begin
         ok = (c >= hold);
         for (int j = c - hold + 1; j <= c; j++)
            if (j >= 1 && miss_at(j - 1) != '0) ok = 1'b0;
         if (ok) return pk(1'b1, 1'b0, c, c, '0);
      end
      return pk(1'b0, 1'b1, MAXC, 0, miss_at(MAXC - 1));
   endfunction

   // ---------------- monitor ----------------
   logic prev1 = 1'b0;
   logic prev2 = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         check("h1_busy_done_excl", 32'(h1_busy & h1_done), 32'd0);
         check("h1_pass_fail_excl", 32'(h1_pass & h1_fail), 32'd0);
         check("h1_cnt_bound", 32'(h1_cnt > 8'(MAXC)), 32'd0);
         check("h2_busy_done_excl", 32'(h2_busy & h2_done), 32'd0);
         check("h2_pass_fail_excl", 32'(h2_pass & h2_fail), 32'd0);
         check("h2_cnt_bound", 32'(h2_cnt > 8'(MAXC)), 32'd0);
         if (h1_done && !prev1) begin
            if (exp_q1.size() == 0) check("h1_unexpected_done", 32'd1, 32'd0);
            else check("h1_verdict", 32'({h1_pass, h1_fail, h1_cnt, h1_mc, h1_miss}),
                       32'(exp_q1.pop_front()));
         end
         if (h2_done && !prev2) begin
            if (exp_q2.size() == 0) check("h2_unexpected_done", 32'd1, 32'd0);
            else check("h2_verdict", 32'({h2_pass, h2_fail, h2_cnt, h2_mc, h2_miss}),
                       32'(exp_q2.pop_front()));
         end
      end
      prev1 = h1_done;
      prev2 = h2_done;
   end

   // ---------------- driver tasks ----------------
   task automatic load_dir(input logic [5:0] f4_ok, input logic [N-1:0] en);
      for (int c = 0; c < 6; c++) begin
         seq_exp[c] = {F4, F3, F2};
         seq_obs[c] = {(f4_ok[c] ? F4 : 32'h0000_0000), F3, F2};
      end
      seq_en = en;
   endtask

   task automatic load_rand();
      logic [W-1:0] e;
      logic [W-1:0] o;
      bool_loop: for (int c = 0; c < 6; c++) begin
         for (int ch = 0; ch < N; ch++) begin
            e = $urandom();
            o = e;
            case ($urandom_range(0, 5))
               0: o = e ^ (32'h1 << $urandom_range(0, 31));
               1: begin e = 32'h0000_0000; o = 32'h8000_0000; end
               default: o = e;
            endcase
            seq_exp[c][ch*W +: W] = e;
            seq_obs[c][ch*W +: W] = o;
         end
      end
      seq_en = N'($urandom_range(0, 7));
   endtask

   task automatic push(input logic [20:0] e1, input logic [20:0] e2);
      exp_q1.push_back(e1);
      exp_q2.push_back(e2);
   endtask

   task automatic start_pulse();
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic drive_cycle(input int k);
      i_obs = seq_obs[k];
      i_exp = seq_exp[k];
      i_en  = seq_en;
   endtask

   task automatic drive_run(input bit mid_start, input bit hold_end);
      for (int k = 0; k < 6; k++) begin
         drive_cycle(k);
         if (mid_start) i_start = (k == 1);
         if (hold_end && k == 5) i_start = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic dir_case(input logic [5:0] f4_ok, input logic [N-1:0] en,
                           input logic [20:0] e1, input logic [20:0] e2);
      load_dir(f4_ok, en);
      push(e1, e2);
      start_pulse();
      drive_run(1'b0, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_obs = '0; i_exp = '0; i_en = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("h1_reset_outputs", 32'({h1_busy, h1_done, h1_pass, h1_fail, h1_cnt, h1_mc, h1_miss}), 32'd0);
      check("h2_reset_outputs", 32'({h2_busy, h2_done, h2_pass, h2_fail, h2_cnt, h2_mc, h2_miss}), 32'd0);

      // Timeout with start held into DONE: back-to-back restart, verdict cleared.
      load_dir(6'b000000, 3'b111);
      push(pk(0, 1, 6, 0, 3'b100), pk(0, 1, 6, 0, 3'b100));
      start_pulse();
      drive_run(1'b0, 1'b1);
      @(posedge clk); #1;
      i_start = 1'b0;
      check("h1_restart", 32'({h1_busy, h1_done, h1_pass, h1_fail, h1_cnt, h1_mc, h1_miss}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 3'b000}));
      check("h2_restart", 32'({h2_busy, h2_done, h2_pass, h2_fail, h2_cnt, h2_mc, h2_miss}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 3'b000}));

      // add.s: f4 lands at cycle 4; start pulsed mid-run must be ignored.
      load_dir(6'b111000, 3'b111);
      push(pk(1, 0, 4, 4, 3'b000), pk(1, 0, 5, 5, 3'b000));
      drive_run(1'b1, 1'b0);

      dir_case(6'b111010, 3'b111, pk(1, 0, 2, 2, 3'b000), pk(1, 0, 5, 5, 3'b000));
      dir_case(6'b000000, 3'b011, pk(1, 0, 1, 1, 3'b000), pk(1, 0, 2, 2, 3'b000));
      dir_case(6'b000000, 3'b000, pk(1, 0, 1, 1, 3'b000), pk(1, 0, 2, 2, 3'b000));
      dir_case(6'b100000, 3'b111, pk(1, 0, 6, 6, 3'b000), pk(0, 1, 6, 0, 3'b000));
      dir_case(6'b110000, 3'b111, pk(1, 0, 5, 5, 3'b000), pk(1, 0, 6, 6, 3'b000));

      // Async reset in RUN cycle 3, no clock edge involved.
      load_dir(6'b000000, 3'b111);
      start_pulse();
      drive_cycle(0); @(posedge clk); #1;
      drive_cycle(1); @(posedge clk); #1;
      check("h1_cnt_before_reset", 32'(h1_cnt), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("h1_async_reset", 32'({h1_busy, h1_done, h1_pass, h1_fail, h1_cnt, h1_mc, h1_miss}), 32'd0);
      check("h2_async_reset", 32'({h2_busy, h2_done, h2_pass, h2_fail, h2_cnt, h2_mc, h2_miss}), 32'd0);
      check("h1_state_idle", 32'(h1_state), 32'(ST_IDLE));
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      load_dir(6'b111000, 3'b111);
      push(pk(1, 0, 4, 4, 3'b000), pk(1, 0, 5, 5, 3'b000));
      start_pulse();
      check("h1_post_reset_start", 32'({h1_busy, h1_cnt}), 32'({1'b1, 8'd1}));
      check("h2_post_reset_start", 32'({h2_busy, h2_cnt}), 32'({1'b1, 8'd1}));
      drive_run(1'b0, 1'b0);

      // Randomized runs against the window model.
      for (int r = 0; r < 40; r++) begin
         load_rand();
         push(model(1), model(2));
         start_pulse();
         drive_run(1'b0, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("h1_queue_drained", 32'(exp_q1.size()), 32'd0);
      check("h2_queue_drained", 32'(exp_q2.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
